// File: rtl/circle_seq_pkg.sv
// Shared types for the circle sequencer: FSM states, shape-table entry layout, 3-bit RGB colours.
// Pure definitions; no latency or flow-control behaviour lives here.
package circle_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FETCH = 3'd2,
        LOAD  = 3'd3,
        DRAW  = 3'd4,
        NEXT  = 3'd5,
        WAIT  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam int SHAPE_X_W = 8;
    localparam int SHAPE_Y_W = 7;
    localparam int SHAPE_R_W = 8;

    // Table word layout, MSB first; the top slices shape_data in this same order.
    typedef struct packed {
        logic [2:0]           colour;
        logic [SHAPE_X_W-1:0] cx;
        logic [SHAPE_Y_W-1:0] cy;
        logic [SHAPE_R_W-1:0] radius;
    } shape_t;

    localparam logic [2:0] BLACK   = 3'd0;
    localparam logic [2:0] BLUE    = 3'd1;
    localparam logic [2:0] GREEN   = 3'd2;
    localparam logic [2:0] CYAN    = 3'd3;
    localparam logic [2:0] RED     = 3'd4;
    localparam logic [2:0] MAGENTA = 3'd5;
    localparam logic [2:0] YELLOW  = 3'd6;
    localparam logic [2:0] WHITE   = 3'd7;

endpackage

// File: rtl/circle_seq_vga_mux.sv
// Selects the fill or circle pixel stream onto the VGA port; combinational, no backpressure.
// Exactly one source or none drives the port, and an unselected source never leaks through.
module circle_seq_vga_mux #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           sel_fill,
    input  logic           sel_circ,
    input  logic [X_W-1:0] fill_x,
    input  logic [Y_W-1:0] fill_y,
    input  logic [2:0]     fill_colour_in,
    input  logic           fill_plot,
    input  logic [X_W-1:0] circ_x,
    input  logic [Y_W-1:0] circ_y,
    input  logic [2:0]     circ_colour,
    input  logic           circ_plot,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [2:0]     vga_colour,
    output logic           vga_plot
);

    always_comb begin
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        if (sel_fill) begin
            vga_x      = fill_x;
            vga_y      = fill_y;
            vga_colour = fill_colour_in;
            vga_plot   = fill_plot;
        end else if (sel_circ) begin
            vga_x      = circ_x;
            vga_y      = circ_y;
            vga_colour = circ_colour;
            vga_plot   = circ_plot;
        end
    end

endmodule

// File: rtl/circle_sequencer.sv
// Clears the screen, then draws each shape-table entry; 2-cycle fetch/load per entry, waits on fill_done/circle_done.
// Optional CIRCLE_SEQ_LOOP_EN: restart from the screen clear after the last entry instead of parking in DONE.
module circle_sequencer
    import circle_seq_pkg::*;
#(
    parameter  int N_SHAPES = 16,
    parameter  int X_W      = 8,
    parameter  int Y_W      = 7,
    parameter  int R_W      = 8,
    localparam int IDX_W    = $clog2(N_SHAPES)
) (
    input  logic                     CLOCK_50,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     step_mode,
    input  logic                     step,
    input  logic [2:0]               fill_colour,
    output logic [IDX_W-1:0]         shape_addr,
    input  logic [3+X_W+Y_W+R_W-1:0] shape_data,
    output logic                     fill_start,
    input  logic                     fill_done,
    input  logic [X_W-1:0]           fill_x,
    input  logic [Y_W-1:0]           fill_y,
    input  logic [2:0]               fill_colour_in,
    input  logic                     fill_plot,
    output logic                     circle_start,
    input  logic                     circle_done,
    output logic [2:0]               circle_colour,
    output logic [X_W-1:0]           centre_x,
    output logic [Y_W-1:0]           centre_y,
    output logic [R_W-1:0]           radius,
    input  logic [X_W-1:0]           circ_x,
    input  logic [Y_W-1:0]           circ_y,
    input  logic [2:0]               circ_colour,
    input  logic                     circ_plot,
    output logic [X_W-1:0]           vga_x,
    output logic [Y_W-1:0]           vga_y,
    output logic [2:0]               vga_colour,
    output logic                     vga_plot,
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         index
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SHAPES - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] index_nxt;

    logic [2:0]       sd_colour;
    logic [X_W-1:0]   sd_cx;
    logic [Y_W-1:0]   sd_cy;
    logic [R_W-1:0]   sd_radius;

    // The fill engine takes the clear colour straight from the top level; it is not consumed here.
    logic             unused_fill_colour;
    assign unused_fill_colour = ^fill_colour;

    assign {sd_colour, sd_cx, sd_cy, sd_radius} = shape_data;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            index <= '0;
        end else begin
            state <= state_nxt;
            index <= index_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        index_nxt = index;
        if (abort) begin
            state_nxt = IDLE;
            index_nxt = '0;
        end else begin
            case (state)
                IDLE:  if (start) state_nxt = FILL;
                FILL: begin
                    if (fill_done) begin
                        state_nxt = FETCH;
                        index_nxt = '0;
                    end
                end
                FETCH: state_nxt = LOAD;
                LOAD:  state_nxt = (sd_radius == '0) ? NEXT : DRAW;
                DRAW:  if (circle_done) state_nxt = NEXT;
                NEXT: begin
                    if (index == LAST_IDX) begin
`ifdef CIRCLE_SEQ_LOOP_EN
                        state_nxt = FILL;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        index_nxt = index + 1'b1;
                        state_nxt = step_mode ? WAIT : FETCH;
                    end
                end
                WAIT:  if (step) state_nxt = FETCH;
                DONE:  if (start) state_nxt = FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Table data arrives one cycle after shape_addr, so LOAD captures what FETCH addressed.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            circle_colour <= '0;
            centre_x      <= '0;
            centre_y      <= '0;
            radius        <= '0;
        end else if (state == LOAD && !abort) begin
            circle_colour <= sd_colour;
            centre_x      <= sd_cx;
            centre_y      <= sd_cy;
            radius        <= sd_radius;
        end
    end

    assign shape_addr   = index;
    assign fill_start   = (state == FILL) && !abort;
    assign circle_start = (state == DRAW) && !abort;
    assign busy         = (state == FILL) || (state == FETCH) || (state == LOAD) ||
                          (state == DRAW) || (state == NEXT)  || (state == WAIT);
    assign done         = (state == DONE);

    circle_seq_vga_mux #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_vga_mux (
        .sel_fill       (state == FILL),
        .sel_circ       (state == DRAW),
        .fill_x         (fill_x),
        .fill_y         (fill_y),
        .fill_colour_in (fill_colour_in),
        .fill_plot      (fill_plot),
        .circ_x         (circ_x),
        .circ_y         (circ_y),
        .circ_colour    (circ_colour),
        .circ_plot      (circ_plot),
        .vga_x          (vga_x),
        .vga_y          (vga_y),
        .vga_colour     (vga_colour),
        .vga_plot       (vga_plot)
    );

endmodule

// File: doc/circle_sequencer.md
CIRCLE_SEQUENCER -- requirements
Module: circle_sequencer

Interface
REQ-001 SHALL have parameter N_SHAPES, default 16, meaning number of shape-table entries (2..256).
REQ-002 SHALL have parameter X_W, default 8, meaning x-coordinate width.
REQ-003 SHALL have parameter Y_W, default 7, meaning y-coordinate width.
REQ-004 SHALL have parameter R_W, default 8, meaning radius width; IDX_W = $clog2(N_SHAPES) is derived.
REQ-005 SHALL have port CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports start/abort/step_mode/step  input  1 each  begin sequence / return to idle / enable single-step / advance one shape.
REQ-008 SHALL have port fill_colour  input  3  screen-clear colour.
REQ-009 SHALL have ports shape_addr  output  IDX_W  and  shape_data  input  3+X_W+Y_W+R_W  {colour,cx,cy,radius}, valid one cycle after shape_addr.
REQ-010 SHALL have ports fill_start output 1; fill_done input 1; fill_x/fill_y/fill_colour_in/fill_plot inputs X_W/Y_W/3/1.
REQ-011 SHALL have ports circle_start output 1; circle_done input 1; circle_colour/centre_x/centre_y/radius outputs 3/X_W/Y_W/R_W; circ_x/circ_y/circ_colour/circ_plot inputs X_W/Y_W/3/1.
REQ-012 SHALL have ports vga_x/vga_y/vga_colour/vga_plot  output  X_W/Y_W/3/1  muxed pixel stream; busy/done output 1; index output IDX_W.

Function
REQ-013 SHALL implement states IDLE, FILL, FETCH, LOAD, DRAW, NEXT, WAIT, DONE.
REQ-014 SHALL go IDLE->FILL, or DONE->FILL, on start=1; start ignored in all other states.
REQ-015 SHALL hold fill_start=1 throughout FILL; on fill_done=1 go to FETCH with index=0.
REQ-016 SHALL drive shape_addr=index in FETCH; LOAD registers shape_data into circle_colour/centre_x/centre_y/radius (one-cycle table latency).
REQ-017 SHALL go LOAD->NEXT when the loaded radius is 0 (entry skipped, circle_start never asserted), else LOAD->DRAW.
REQ-018 SHALL hold circle_start=1 throughout DRAW; on circle_done=1 go to NEXT, with circle_start low in NEXT.
REQ-019 SHALL, in NEXT, go to DONE if index==N_SHAPES-1, else increment index and go to WAIT if step_mode=1, otherwise FETCH.
REQ-020 SHALL leave WAIT for FETCH on step=1 only; step ignored in every other state.
REQ-021 SHALL route vga_* from fill_* in FILL, from circ_* in DRAW, else drive vga_plot=0 and vga_x/vga_y/vga_colour=0; no OR-ing of sources.
REQ-022 SHALL on abort=1 in any state go to IDLE next cycle, deassert fill_start/circle_start, index=0; abort has priority over start, step and done inputs.
REQ-023 SHALL assert busy in FILL..WAIT, done only in DONE; index visible at all times.
REQ-024 SHALL treat coordinates as unsigned, passed unmodified; off-screen clipping belongs to the circle engine.

Reset
REQ-025 SHALL, while rst_n=0, force state=IDLE, index=0, all circle parameter registers 0, and every output 0.
REQ-026 SHALL, on reset mid-FILL or mid-DRAW, drop fill_start/circle_start immediately (asynchronously).

Configuration
REQ-027 SHALL, with CIRCLE_SEQ_LOOP_EN defined, go NEXT->FILL after the last entry (continuous redraw, done never asserted); without it, go NEXT->DONE and hold.

Structure
REQ-028 SHALL place the state enum, packed shape_t struct {colour,cx,cy,radius} and 3-bit colour constants (BLACK..WHITE) in package circle_seq_pkg.
REQ-029 SHALL implement the pixel-stream routing as sub-module circle_seq_vga_mux.

Verification
REQ-030 SHALL check: N_SHAPES=4, start pulse, fill_done after 10 cycles -> fill_start high 10 cycles; four DRAW phases, index 0..3; done=1, busy=0 afterwards.
REQ-031 SHALL check: entry 2 radius=0 -> circle_start never asserted for index 2; index goes 1->2->3 without DRAW.
REQ-032 SHALL check: step_mode=1 -> sequencer parks in WAIT after each shape until step pulse; no step for 100 cycles -> index unchanged.
REQ-033 SHALL check: abort during DRAW of index 1 -> IDLE next cycle, circle_start=0, vga_plot=0, index=0; a later start redraws from FILL.
REQ-034 SHALL check: fill_plot=1 during DRAW and circ_plot=1 during FILL -> vga_plot=0 (other source never leaks).
REQ-035 SHALL check: CIRCLE_SEQ_LOOP_EN defined, N_SHAPES=2 -> FILL re-entered after index 1, done stays 0 across three loops.
